// File: rtl/point_decompress_if.sv
// Compressed point in, affine point out, for point_decompress.
`timescale 1ns/1ps
`ifndef WIDTH
`define WIDTH 193
`endif

interface point_decompress_if;
  logic [`WIDTH:0] x1;
  logic            sign1;
  logic            zero1;
  logic            done;
  logic [`WIDTH:0] x3;
  logic [`WIDTH:0] y3;
  logic            zero3;
  logic            valid3;

  modport master (
    output x1, sign1, zero1,
    input  done, x3, y3, zero3, valid3
  );

  modport slave (
    input  x1, sign1, zero1,
    output done, x3, y3, zero3, valid3
  );
endinterface

// File: rtl/point_decompress.sv
// Point decompression on y^2 = x^3 - x + 1 over GF(3^97), x^97 + x^12 + 2.
// Macro POINT_DECOMPRESS_CHECK_EN adds the r*r == a residuosity check.
`timescale 1ns/1ps
`ifndef WIDTH
`define WIDTH 193
`endif

package f3m_pkg;
  localparam int M = 97;
  typedef logic [`WIDTH:0] elem_t;

  function automatic logic [1:0] tadd(logic [1:0] a, logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [1:0] tneg(logic [1:0] a);
    return {a[0], a[1]};
  endfunction

  function automatic elem_t fadd(elem_t a, elem_t b);
    elem_t r;
    for (int i = 0; i < M; i++)
      r[2*i +: 2] = tadd(a[2*i +: 2], b[2*i +: 2]);
    return r;
  endfunction

  function automatic elem_t fneg(elem_t a);
    elem_t r;
    for (int i = 0; i < M; i++)
      r[2*i +: 2] = tneg(a[2*i +: 2]);
    return r;
  endfunction

  // x * a: the trit leaving x^96 re-enters as 2x^12 + 1
  function automatic elem_t fmulx(elem_t a);
    elem_t r;
    logic [1:0] t;
    t = a[2*M-1 -: 2];
    r = {a[2*M-3:0], t};
    r[25:24] = tadd(a[23:22], tneg(t));
    return r;
  endfunction

  function automatic elem_t fscale(elem_t a, logic [1:0] t);
    if (t == 2'd1) return a;
    if (t == 2'd2) return fneg(a);
    return '0;
  endfunction

  function automatic elem_t fcube(elem_t a);
    logic [1:0] c [3*M-2];
    elem_t r;
    for (int i = 0; i < 3*M-2; i++) c[i] = 2'b00;
    for (int i = 0; i < M; i++) c[3*i] = a[2*i +: 2];
    for (int d = 3*M-3; d >= M; d--) begin
      c[d-M]    = tadd(c[d-M], c[d]);
      c[d-M+12] = tadd(c[d-M+12], tneg(c[d]));
    end
    for (int i = 0; i < M; i++) r[2*i +: 2] = c[i];
    return r;
  endfunction
endpackage

module f3m_cubic import f3m_pkg::*; (
  input  elem_t a,
  output elem_t c
);
  assign c = fcube(a);
endmodule

module f3m_add import f3m_pkg::*; (
  input  elem_t a,
  input  elem_t b,
  output elem_t c
);
  assign c = fadd(a, b);
endmodule

module f3m_sub import f3m_pkg::*; (
  input  elem_t a,
  input  elem_t b,
  output elem_t c
);
  assign c = fadd(a, fneg(b));
endmodule

module f3m_neg import f3m_pkg::*; (
  input  elem_t a,
  output elem_t c
);
  assign c = fneg(a);
endmodule

// Digit-serial multiplier: 8 trits of b per cycle, 13 cycles after reset.
module f3m_mult import f3m_pkg::*; (
  input  logic  clk,
  input  logic  reset,
  input  elem_t a,
  input  elem_t b,
  output elem_t c,
  output logic  done
);
  localparam int D     = 8;
  localparam int STEPS = (M + D - 1) / D;
  localparam int BW    = 2 * D * STEPS;

  elem_t          areg;
  elem_t          acc;
  logic [BW-1:0]  bs;
  logic [3:0]     cnt;

  function automatic elem_t step(elem_t x, elem_t m, logic [2*D-1:0] dig);
    elem_t r;
    r = x;
    for (int j = D - 1; j >= 0; j--)
      r = fadd(fmulx(r), fscale(m, dig[2*j +: 2]));
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      areg <= a;
      bs   <= BW'(b);
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (!done) begin
      acc  <= step(acc, areg, bs[BW-1 -: 2*D]);
      bs   <= bs << (2*D);
      cnt  <= cnt + 4'd1;
      done <= (cnt == 4'(STEPS - 1));
    end
  end

  assign c = acc;
endmodule

module point_decompress import f3m_pkg::*; #(
  parameter int LOOP_COUNT = 47
) (
  input logic               clk,
  input logic               reset,
  point_decompress_if.slave bus
);
  localparam int    CW  = $clog2(LOOP_COUNT + 1);
  localparam elem_t ONE = elem_t'(1);

  typedef enum logic [2:0] {
    INIT, SQ, LOOP, FIN,
`ifdef POINT_DECOMPRESS_CHECK_EN
    CHK,
`endif
    OUT, OUT_INF, DONE
  } state_t;

  state_t        state_q, state_n;
  elem_t         a, x1c, xd;
  elem_t         a2_q, a2_n;
  elem_t         r_q, r_n;
  elem_t         r3, r9, neg_r, y_sel;
  elem_t         ma, mb, prod;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          mrst_q, mrst_n;
  logic          mdone, mdone_q, mdone_d, pulse;
  logic          dn_q, dn_n;
  elem_t         x3_q, x3_n;
  elem_t         y3_q, y3_n;
  logic          z3_q, z3_n;
  logic          v3_q, v3_n;
`ifdef POINT_DECOMPRESS_CHECK_EN
  logic          ok_q, ok_n;
`endif

  f3m_cubic u_cx (.a(bus.x1), .c(x1c));
  f3m_sub   u_sb (.a(x1c), .b(bus.x1), .c(xd));
  f3m_add   u_ad (.a(xd), .b(ONE), .c(a));
  f3m_cubic u_c1 (.a(r_q), .c(r3));
  f3m_cubic u_c2 (.a(r3), .c(r9));
  f3m_neg   u_ng (.a(r_q), .c(neg_r));

  f3m_mult u_mul (
    .clk  (clk),
    .reset(reset | mrst_q),
    .a    (ma),
    .b    (mb),
    .c    (prod),
    .done (mdone)
  );

  // done is registered once more before the edge detect
  assign pulse = mdone_q & ~mdone_d;

  always_comb begin
    ma = a;
    mb = a;
    unique case (state_q)
      LOOP: begin ma = r9; mb = a2_q; end
      FIN:  begin ma = r3; mb = a; end
`ifdef POINT_DECOMPRESS_CHECK_EN
      CHK:  begin ma = r_q; mb = r_q; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    y_sel = '0;
    if (r_q != neg_r)
      y_sel = (bus.sign1 ^ (r_q < neg_r)) ? r_q : neg_r;
  end

  always_comb begin
    state_n = state_q;
    a2_n    = a2_q;
    r_n     = r_q;
    cnt_n   = cnt_q;
    mrst_n  = 1'b0;
    dn_n    = dn_q;
    x3_n    = x3_q;
    y3_n    = y3_q;
    z3_n    = z3_q;
    v3_n    = v3_q;
`ifdef POINT_DECOMPRESS_CHECK_EN
    ok_n    = ok_q;
`endif
    unique case (state_q)
      INIT: begin
        if (bus.zero1) state_n = OUT_INF;
        else begin
          mrst_n  = 1'b1;
          state_n = SQ;
        end
      end
      SQ: if (pulse) begin
        a2_n    = prod;
        r_n     = prod;
        mrst_n  = 1'b1;
        state_n = LOOP;
      end
      LOOP: if (pulse) begin
        r_n    = prod;
        cnt_n  = cnt_q - CW'(1);
        mrst_n = 1'b1;
        if (cnt_q == CW'(1)) state_n = FIN;
      end
      FIN: if (pulse) begin
        r_n = prod;
`ifdef POINT_DECOMPRESS_CHECK_EN
        mrst_n  = 1'b1;
        state_n = CHK;
`else
        state_n = OUT;
`endif
      end
`ifdef POINT_DECOMPRESS_CHECK_EN
      CHK: if (pulse) begin
        ok_n    = (prod == a);
        state_n = OUT;
      end
`endif
      OUT: begin
        x3_n = bus.x1;
        y3_n = y_sel;
        z3_n = 1'b0;
`ifdef POINT_DECOMPRESS_CHECK_EN
        v3_n = ok_q;
`else
        v3_n = 1'b1;
`endif
        dn_n    = 1'b1;
        state_n = DONE;
      end
      OUT_INF: begin
        x3_n    = '0;
        y3_n    = '0;
        z3_n    = 1'b1;
        v3_n    = 1'b1;
        dn_n    = 1'b1;
        state_n = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      a2_q    <= '0;
      r_q     <= '0;
      cnt_q   <= CW'(LOOP_COUNT);
      mrst_q  <= 1'b0;
      mdone_q <= 1'b0;
      mdone_d <= 1'b0;
      dn_q    <= 1'b0;
      x3_q    <= '0;
      y3_q    <= '0;
      z3_q    <= 1'b1;
      v3_q    <= 1'b0;
`ifdef POINT_DECOMPRESS_CHECK_EN
      ok_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      a2_q    <= a2_n;
      r_q     <= r_n;
      cnt_q   <= cnt_n;
      mrst_q  <= mrst_n;
      mdone_q <= mdone;
      mdone_d <= mdone_q;
      dn_q    <= dn_n;
      x3_q    <= x3_n;
      y3_q    <= y3_n;
      z3_q    <= z3_n;
      v3_q    <= v3_n;
`ifdef POINT_DECOMPRESS_CHECK_EN
      ok_q    <= ok_n;
`endif
    end
  end

  assign bus.done   = dn_q;
  assign bus.x3     = x3_q;
  assign bus.y3     = y3_q;
  assign bus.zero3  = z3_q;
  assign bus.valid3 = v3_q;
endmodule

// File: tb/tb_point_decompress.sv
// Scoreboard bench for point_decompress against a polynomial-arithmetic model.
`timescale 1ns/1ps
`ifndef WIDTH
`define WIDTH 193
`endif

module tb_point_decompress;
  typedef logic [`WIDTH:0] elem_t;
  typedef struct {
    elem_t x;
    elem_t y;
    logic  z;
    logic  v;
    int    lat;
    string tag;
  } exp_t;

  localparam int LM = 13;
`ifdef POINT_DECOMPRESS_CHECK_EN
  localparam int   NMUL  = 50;
  localparam logic BAD_V = 1'b0;
`else
  localparam int   NMUL  = 49;
  localparam logic BAD_V = 1'b1;
`endif
  localparam int    LAT  = NMUL * (LM + 3) + 2;
  localparam elem_t ONE  = elem_t'(1);
  localparam elem_t MONE = elem_t'(2);

  logic clk = 1'b0;
  logic reset = 1'b1;

  point_decompress_if bus();

  point_decompress dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  exp_t q[$];
  int   dig[$];
  logic done_prev = 1'b0;
  exp_t mex;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string name, input elem_t got, input elem_t exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic elem_t m_lin(elem_t a, elem_t b, int k);
    elem_t r;
    for (int i = 0; i < 97; i++)
      r[2*i +: 2] = 2'((int'(a[2*i +: 2]) + k * int'(b[2*i +: 2])) % 3);
    return r;
  endfunction

  function automatic elem_t m_mul(elem_t a, elem_t b);
    int    p [193];
    elem_t r;
    for (int i = 0; i < 193; i++) p[i] = 0;
    for (int i = 0; i < 97; i++)
      for (int j = 0; j < 97; j++)
        p[i+j] = (p[i+j] + int'(a[2*i +: 2]) * int'(b[2*j +: 2])) % 3;
    for (int d = 192; d >= 97; d--) begin
      p[d-97] = (p[d-97] + p[d]) % 3;
      p[d-85] = (p[d-85] + 2 * p[d]) % 3;
    end
    r = '0;
    for (int i = 0; i < 97; i++) r[2*i +: 2] = 2'(p[i]);
    return r;
  endfunction

  function automatic elem_t m_pow(elem_t a);
    elem_t r, a2;
    r  = ONE;
    a2 = m_mul(a, a);
    foreach (dig[i]) begin
      r = m_mul(m_mul(r, r), r);
      if (dig[i] == 1) r = m_mul(r, a);
      else if (dig[i] == 2) r = m_mul(r, a2);
    end
    return r;
  endfunction

  function automatic elem_t m_rhs(elem_t x);
    return m_lin(m_lin(m_mul(m_mul(x, x), x), x, 2), ONE, 1);
  endfunction

  function automatic elem_t m_pick(elem_t r, logic s);
    elem_t n;
    n = m_lin('0, r, 2);
    if (r == n) return '0;
    if (s) return (r > n) ? r : n;
    return (r < n) ? r : n;
  endfunction

  function automatic elem_t m_rand();
    elem_t r;
    for (int i = 0; i < 97; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1 && !done_prev) begin
      if (q.size() == 0) begin
        chk("unexpected_done", elem_t'(bus.done), '0);
      end else begin
        mex = q.pop_front();
        chk({mex.tag, ".x3"}, bus.x3, mex.x);
        chk({mex.tag, ".y3"}, bus.y3, mex.y);
        chk({mex.tag, ".zero3"}, elem_t'(bus.zero3), elem_t'(mex.z));
        chk({mex.tag, ".valid3"}, elem_t'(bus.valid3), elem_t'(mex.v));
        chk({mex.tag, ".latency"}, elem_t'(unsigned'(cyc)), elem_t'(unsigned'(mex.lat)));
      end
    end
    done_prev = bus.done;
  end

  task automatic start(input elem_t x, input logic s, input logic z);
    @(posedge clk); #1;
    reset     = 1'b1;
    bus.x1    = x;
    bus.sign1 = s;
    bus.zero1 = z;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic finish_run(input exp_t ex);
    q.push_back(ex);
    for (int i = 0; i < LAT + 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL %s.timeout: done not seen within %0d cycles", ex.tag, LAT + 100);
      q.delete();
    end
  endtask

  function automatic exp_t mk(elem_t x, logic z, elem_t y, logic v, string tag);
    exp_t e;
    e.x   = z ? '0 : x;
    e.y   = y;
    e.z   = z;
    e.v   = v;
    e.lat = z ? 2 : LAT;
    e.tag = tag;
    return e;
  endfunction

  task automatic run(input elem_t x, input logic s, input logic z,
                     input elem_t y, input logic v, input string tag);
    start(x, s, z);
    finish_run(mk(x, z, y, v, tag));
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, ".done"}, elem_t'(bus.done), '0);
    chk({tag, ".x3"}, bus.x3, '0);
    chk({tag, ".y3"}, bus.y3, '0);
    chk({tag, ".zero3"}, elem_t'(bus.zero3), elem_t'(1'b1));
    chk({tag, ".valid3"}, elem_t'(bus.valid3), '0);
  endtask

  task automatic rst_chk(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_vals(tag);
  endtask

  task automatic find_point(input logic want_res, output elem_t x, output elem_t r);
    elem_t a;
    for (int t = 0; t < 200; t++) begin
      x = m_rand();
      a = m_rhs(x);
      r = m_pow(a);
      if ((m_mul(r, r) == a) == want_res) break;
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [159:0] p3, e;
    elem_t        x, r, y;
    logic         s;

    p3 = 160'd1;
    repeat (97) p3 = p3 * 160'd3;
    e = (p3 + 160'd1) / 160'd4;
    while (e != 0) begin
      dig.push_front(int'(e % 160'd3));
      e = e / 160'd3;
    end

    bus.x1    = '0;
    bus.sign1 = 1'b0;
    bus.zero1 = 1'b0;
    rst_chk("por");

    run(m_rand(), 1'b0, 1'b1, '0, 1'b1, "inf");
    run('0,   1'b0, 1'b0, ONE,  1'b1, "x0_s0");
    run('0,   1'b1, 1'b0, MONE, 1'b1, "x0_s1");
    run(ONE,  1'b0, 1'b0, ONE,  1'b1, "xone_s0");
    run(MONE, 1'b1, 1'b0, MONE, 1'b1, "xmone_s1");

    for (int k = 0; k < 20; k++) begin
      find_point(1'b1, x, r);
      y = ($urandom_range(0, 1) != 0) ? r : m_lin('0, r, 2);
      s = (y > m_lin('0, y, 2));
      run(x, s, 1'b0, y, 1'b1, $sformatf("rt%0d", k));
      if (k == 0) rst_chk("after_run");
    end

    find_point(1'b0, x, r);
    s = 1'($urandom_range(0, 1));
    run(x, s, 1'b0, m_pick(r, s), BAD_V, "nonres");

    find_point(1'b1, x, r);
    s = 1'($urandom_range(0, 1));
    start(x, s, 1'b0);
    repeat (300) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_vals("midreset");
    reset = 1'b0;
    finish_run(mk(x, 1'b0, m_pick(r, s), 1'b1, "restart"));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
